// File: rtl/duck_pkg.sv
// Shared constants and types for the duck shooter control path.
// Holds hitbox/screen geometry, the shot resolver state enum and the
// hit-box span test used by the shot resolver.
package duck_pkg;

  localparam int DUCK_W   = 64;
  localparam int DUCK_H   = 64;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int COORD_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READY    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_DONE     = 3'd4
  } shot_state_t;

  // True when p lies in [lo, lo + size). Operands are 12 bits wide so that
  // an 11-bit box origin plus the box size can never wrap.
  function automatic logic in_span(input logic [11:0] p,
                                   input logic [11:0] lo,
                                   input int          size);
    return (p >= lo) && (p < lo + 12'(size));
  endfunction

endpackage

// File: rtl/ctl_shot_sync_edge.sv
// sync_edge: brings an asynchronous 1-bit input into the clk domain through
// two flops, then emits a registered one-cycle pulse on each rising edge.
// A raw edge shows up on o_rise three clk edges later.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  // Two-flop synchroniser, one history flop and a registered edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/ctl_shot.sv
// ctl_shot: shot/hit resolver. Turns trigger edges into shots, tests the
// sampled cursor against the duck hitbox, limits shots per round, enforces
// a frame-counted cooldown between shots and keeps a saturating hit count.
// Optional feature macro: SHOT_FLASH_EN adds the screen_flash output.
//
// Handshake: there is no back-pressure. round_start, new_frame and the
// internal trig_rise are single-cycle events consumed in the cycle they are
// high; shot_fired and shot_miss are single-cycle events presented to the
// consumer with no ready, so a consumer must sample them every cycle.
module ctl_shot #(
  parameter int DUCK_W          = duck_pkg::DUCK_W,
  parameter int DUCK_H          = duck_pkg::DUCK_H,
  parameter int SHOTS_PER_ROUND = 3,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_frame,
  input  logic                  round_start,
  input  logic                  trigger,
  input  logic [10:0]           cursor_x,
  input  logic [10:0]           cursor_y,
  input  logic [10:0]           duck_x,
  input  logic [10:0]           duck_y,
  input  logic                  duck_show,
  output logic                  shot_fired,
  output logic                  duck_hit,
  output logic                  shot_miss,
  output logic [1:0]            shots_left,
  output logic [7:0]            hit_count,
`ifdef SHOT_FLASH_EN
  output logic                  screen_flash,
`endif
  output duck_pkg::shot_state_t dbg_state
);

  import duck_pkg::*;

  localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_ROUND);
  localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_FRAMES - 1);

  shot_state_t r_state;
  shot_state_t w_state_nxt;

  logic        w_trig_rise;
  logic        w_hit;
  logic        w_reload;
  logic        w_sample;
  logic        w_hit_set;
  logic        w_shot_fired;
  logic        w_shot_miss;
  logic        w_cool_clr;
  logic        w_cool_inc;

  logic [10:0] r_cx;
  logic [10:0] r_cy;
  logic [10:0] r_dx;
  logic [10:0] r_dy;
  logic        r_show;
  logic [1:0]  r_shots_left;
  logic        r_duck_hit;
  logic [7:0]  r_hit_count;
  logic [7:0]  r_cool_cnt;

  sync_edge u_trig_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (trigger),
    .o_rise (w_trig_rise)
  );

  // Hit test on the values captured when the shot was taken.
  assign w_hit = r_show
              && in_span({1'b0, r_cx}, {1'b0, r_dx}, DUCK_W)
              && in_span({1'b0, r_cy}, {1'b0, r_dy}, DUCK_H);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle event decode; round_start overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_reload     = 1'b0;
    w_sample     = 1'b0;
    w_hit_set    = 1'b0;
    w_shot_fired = 1'b0;
    w_shot_miss  = 1'b0;
    w_cool_clr   = 1'b0;
    w_cool_inc   = 1'b0;
    if (round_start) begin
      w_state_nxt = ST_READY;
      w_reload    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_READY: begin
          if (w_trig_rise && (r_shots_left != 2'd0)) begin
            w_state_nxt  = ST_CHECK;
            w_sample     = 1'b1;
            w_shot_fired = 1'b1;
          end
        end
        ST_CHECK: begin
          w_cool_clr = 1'b1;
          if (w_hit) w_hit_set   = 1'b1;
          else       w_shot_miss = 1'b1;
          if (w_hit || r_duck_hit || (r_shots_left == 2'd0)) w_state_nxt = ST_DONE;
          else                                               w_state_nxt = ST_COOLDOWN;
        end
        ST_COOLDOWN: begin
          if (new_frame) begin
            if (r_cool_cnt == COOL_LAST) w_state_nxt = ST_READY;
            else                         w_cool_inc  = 1'b1;
          end
        end
        ST_DONE: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture cursor and duck position at the moment the shot is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx   <= '0;
      r_cy   <= '0;
      r_dx   <= '0;
      r_dy   <= '0;
      r_show <= 1'b0;
    end else if (w_sample) begin
      r_cx   <= cursor_x;
      r_cy   <= cursor_y;
      r_dx   <= duck_x;
      r_dy   <= duck_y;
      r_show <= duck_show;
    end
  end

  // Shots remaining and the round's hit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shots_left <= 2'd0;
      r_duck_hit   <= 1'b0;
    end else if (w_reload) begin
      r_shots_left <= SHOTS_INIT;
      r_duck_hit   <= 1'b0;
    end else begin
      if (w_sample && (r_shots_left != 2'd0)) r_shots_left <= r_shots_left - 2'd1;
      if (w_hit_set)                          r_duck_hit   <= 1'b1;
    end
  end

  // Lifetime hit counter, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_hit_count <= 8'd0;
    else if (w_hit_set && (r_hit_count != 8'hFF)) r_hit_count <= r_hit_count + 8'd1;
  end

  // Frame counter for the post-shot cooldown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cool_cnt <= 8'd0;
    else if (w_cool_clr) r_cool_cnt <= 8'd0;
    else if (w_cool_inc) r_cool_cnt <= r_cool_cnt + 8'd1;
  end

`ifdef SHOT_FLASH_EN
  logic [1:0] r_flash_cnt;

  // Flash window: reloaded by every shot, drained by new_frame pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_flash_cnt <= 2'd0;
    else if (w_shot_fired)                     r_flash_cnt <= 2'd2;
    else if (new_frame && (r_flash_cnt != 2'd0)) r_flash_cnt <= r_flash_cnt - 2'd1;
  end

  assign screen_flash = w_shot_fired || (r_flash_cnt != 2'd0);
`endif

  // duck_hit is visible during the check cycle itself, then held by the flag.
  assign shot_fired = w_shot_fired;
  assign shot_miss  = w_shot_miss;
  assign duck_hit   = r_duck_hit | w_hit_set;
  assign shots_left = r_shots_left;
  assign hit_count  = r_hit_count;
  assign dbg_state  = r_state;

endmodule
